// File: rtl/poly_voice_mixer.sv
// Polyphonic sample-playback mixer: per-voice AR envelope, one memory read per voice per frame,
// gain-scaled accumulation and a saturated mono output sample.
`timescale 1ns/1ps
module poly_voice_mixer #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 13,
    parameter int MEM_LATENCY  = 2,
    parameter int GAIN_WIDTH   = 8
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  sample_tick,
    input  logic [NUM_VOICES-1:0]                 gate_in,
    input  logic                                  loop_en,
    output logic                                  mem_rd_out,
    output logic [$clog2(NUM_VOICES)-1:0]         mem_voice_out,
    output logic [ADDR_WIDTH-1:0]                 mem_addr_out,
    input  logic signed [SAMPLE_WIDTH-1:0]        mem_data_in,
    output logic signed [SAMPLE_WIDTH-1:0]        sample_out,
    output logic                                  sample_valid,
    output logic [NUM_VOICES-1:0]                 active_out,
    output logic                                  busy_out
);

    localparam int VW     = $clog2(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_WIDTH + VW + 1;
    localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int CNT_W  = $clog2(NUM_VOICES + MEM_LATENCY + 2);

    localparam logic [CNT_W-1:0] NUM_RD    = CNT_W'(NUM_VOICES);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NUM_VOICES + MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(NUM_VOICES + MEM_LATENCY);

    localparam logic [GAIN_WIDTH-1:0] GAIN_MAX  = '1;
    localparam logic [GAIN_WIDTH-1:0] GAIN_NEAR = GAIN_MAX - 1'b1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(SAMPLE_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} voice_state_e;

    voice_state_e            state_q [NUM_VOICES];
    voice_state_e            state_d [NUM_VOICES];
    voice_state_e            state_mid [NUM_VOICES];
    logic [GAIN_WIDTH-1:0]   gain_q  [NUM_VOICES];
    logic [GAIN_WIDTH-1:0]   gain_d  [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]   addr_q  [NUM_VOICES];
    logic [ADDR_WIDTH-1:0]   addr_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0]   gate_prev_q;
    logic [NUM_VOICES-1:0]   gate_rise;
    logic [NUM_VOICES-1:0]   gate_fall;

    logic                    busy_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    tick_ok;
    logic                    rd;
    logic [VW-1:0]           rd_voice;

    logic [MEM_LATENCY-1:0]  pipe_vld_q;
    logic [GAIN_WIDTH-1:0]   pipe_gain_q [MEM_LATENCY];

    logic signed [PROD_W-1:0]       data_ext;
    logic signed [PROD_W-1:0]       gain_ext;
    logic signed [PROD_W-1:0]       product;
    logic signed [PROD_W-1:0]       scaled_full;
    logic signed [ACC_W-1:0]        contrib;
    logic signed [ACC_W-1:0]        sum;
    logic signed [SAMPLE_WIDTH-1:0] sum_sat;
    logic signed [ACC_W-1:0]        acc_q;
    logic signed [SAMPLE_WIDTH-1:0] sample_q;
    logic                           valid_q;

    assign tick_ok   = sample_tick && !busy_q;
    assign rd        = busy_q && (cnt_q < NUM_RD);
    assign rd_voice  = cnt_q[VW-1:0];
    assign gate_rise = gate_in & ~gate_prev_q;
    assign gate_fall = ~gate_in & gate_prev_q;

    // Gate-edge transitions; the gain rule is then applied to the resulting state.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_mid[v] = state_q[v];
            if (gate_rise[v]) begin
                state_mid[v] = StAttack;
            end else if (gate_fall[v] &&
                         (state_q[v] == StAttack || state_q[v] == StSustain)) begin
                state_mid[v] = StRelease;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_d[v] = state_q[v];
            gain_d[v]  = gain_q[v];
            addr_d[v]  = addr_q[v];
            if (tick_ok) begin
                state_d[v] = state_mid[v];
                if (gate_rise[v]) begin
                    addr_d[v] = '0;
                end
                case (state_mid[v])
                    StAttack: begin
                        if (gain_q[v] >= GAIN_NEAR) begin
                            gain_d[v]  = GAIN_MAX;
                            state_d[v] = StSustain;
                        end else begin
                            gain_d[v] = gain_q[v] + 1'b1;
                        end
                    end
                    StSustain: gain_d[v] = gain_q[v];
                    StRelease: begin
                        if (gain_q[v] <= GAIN_WIDTH'(1)) begin
                            gain_d[v]  = '0;
                            state_d[v] = StIdle;
                        end else begin
                            gain_d[v] = gain_q[v] - 1'b1;
                        end
                    end
                    default: gain_d[v] = '0;
                endcase
            end else if (rd && rd_voice == VW'(v) && state_q[v] != StIdle) begin
                if (addr_q[v] == '1) begin
                    addr_d[v] = '0;
                    if (!loop_en) begin
                        state_d[v] = StIdle;
                        gain_d[v]  = '0;
                    end
                end else begin
                    addr_d[v] = addr_q[v] + 1'b1;
                end
            end
        end
    end

    // Oldest pipeline stage lines up with the data returning from memory this cycle.
    always_comb begin
        data_ext    = PROD_W'(mem_data_in);
        gain_ext    = PROD_W'({1'b0, pipe_gain_q[MEM_LATENCY-1]});
        product     = data_ext * gain_ext;
        scaled_full = product >>> GAIN_WIDTH;
        contrib     = pipe_vld_q[MEM_LATENCY-1] ? ACC_W'(scaled_full) : '0;
        sum         = acc_q + contrib;
        if (sum > SAT_MAX) begin
            sum_sat = SAMPLE_WIDTH'(SAT_MAX);
        end else if (sum < SAT_MIN) begin
            sum_sat = SAMPLE_WIDTH'(SAT_MIN);
        end else begin
            sum_sat = SAMPLE_WIDTH'(sum);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= StIdle;
                gain_q[v]  <= '0;
                addr_q[v]  <= '0;
            end
            gate_prev_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= state_d[v];
                gain_q[v]  <= gain_d[v];
                addr_q[v]  <= addr_d[v];
            end
            if (tick_ok) begin
                gate_prev_q <= gate_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < MEM_LATENCY; k++) begin
                pipe_gain_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= rd;
            pipe_gain_q[0] <= (rd && state_q[rd_voice] != StIdle) ? gain_q[rd_voice] : '0;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_gain_q[k] <= pipe_gain_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (tick_ok) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                acc_q  <= '0;
            end else if (busy_q) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= sum;
                if (cnt_q == LAST_DATA) begin
                    sample_q <= sum_sat;
                    valid_q  <= 1'b1;
                end
                if (cnt_q == FRAME_END) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            active_out[v] = (state_q[v] != StIdle);
        end
    end

    assign mem_rd_out    = rd;
    assign mem_voice_out = rd ? rd_voice : '0;
    assign mem_addr_out  = rd ? addr_q[rd_voice] : '0;
    assign sample_out    = sample_q;
    assign sample_valid  = valid_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Scoreboard bench for poly_voice_mixer: stimulus queues expected samples, a monitor pops them
// on every sample_valid and also tracks read strobes and latency.
`timescale 1ns/1ps
module tb_poly_voice_mixer;

    localparam int NV = 4;
    localparam int LAT = 2;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               sample_tick;
    logic [NV-1:0]      gate_in;
    logic               loop_en;
    logic               mem_rd_out;
    logic [1:0]         mem_voice_out;
    logic [2:0]         mem_addr_out;
    logic signed [15:0] mem_data_in;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic [NV-1:0]      active_out;
    logic               busy_out;

    poly_voice_mixer #(
        .NUM_VOICES  (NV),
        .SAMPLE_WIDTH(16),
        .ADDR_WIDTH  (3),
        .MEM_LATENCY (LAT),
        .GAIN_WIDTH  (4)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .sample_tick  (sample_tick),
        .gate_in      (gate_in),
        .loop_en      (loop_en),
        .mem_rd_out   (mem_rd_out),
        .mem_voice_out(mem_voice_out),
        .mem_addr_out (mem_addr_out),
        .mem_data_in  (mem_data_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .active_out   (active_out),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int                 cyc = 0;
    int                 tests = 0;
    int                 fails = 0;
    int                 rd_count = 0;
    int                 valid_count = 0;
    int                 last_addr0 = -1;
    int                 exp_q[$];
    int                 tick_q[$];
    logic signed [15:0] voice_data [NV];
    logic signed [15:0] mem_d1;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Fixed two-cycle memory: each voice returns its table value.
    always @(posedge clk_in) begin
        mem_d1      <= mem_rd_out ? voice_data[mem_voice_out] : 16'sd0;
        mem_data_in <= mem_d1;
    end

    function automatic void check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial begin : monitor
        int e;
        int t;
        forever begin
            @(negedge clk_in);
            if (mem_rd_out) begin
                rd_count++;
                if (mem_voice_out == 2'd0) last_addr0 = int'(mem_addr_out);
            end
            if (sample_valid) begin
                valid_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_sample_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    t = tick_q.pop_front();
                    check("sample_out", longint'(sample_out), e);
                    check("valid_latency", cyc - t, NV + LAT);
                end
            end
        end
    end

    task automatic set_data(input int d0, input int d1, input int d2, input int d3);
        voice_data[0] = 16'(d0);
        voice_data[1] = 16'(d1);
        voice_data[2] = 16'(d2);
        voice_data[3] = 16'(d3);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (busy_out && n < 40);
        if (busy_out) check("frame_timeout", 1, 0);
    endtask

    task automatic issue_tick(input logic [NV-1:0] gate, input int exp);
        @(negedge clk_in);
        gate_in     = gate;
        sample_tick = 1'b1;
        exp_q.push_back(exp);
        tick_q.push_back(cyc + 1);
        @(posedge clk_in);
        #1 sample_tick = 1'b0;
        check("busy_after_tick", busy_out, 1);
    endtask

    task automatic frame(input logic [NV-1:0] gate, input int exp);
        issue_tick(gate, exp);
        wait_idle();
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    initial begin
        int rd0;
        int v0;
        int n;
        rst_in      = 1'b0;
        sample_tick = 1'b0;
        gate_in     = '0;
        loop_en     = 1'b1;
        set_data(4096, 4096, 4096, 4096);
        repeat (3) @(negedge clk_in);
        check("rst_sample_out", sample_out, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_mem_rd", mem_rd_out, 0);
        check("rst_active", active_out, 0);
        check("rst_busy", busy_out, 0);
        rst_in = 1'b1;

        // Attack ramp, one voice, then sustain.
        for (int k = 1; k <= 15; k++) begin
            frame(4'b0001, 256 * k);
            if (k == 1) check("attack_active", active_out, 4'b0001);
        end
        frame(4'b0001, 3840);
        check("sustain_active", active_out, 4'b0001);

        // Release down to 8, retrigger restarts at address 0 from gain 8.
        for (int g = 14; g >= 8; g--) frame(4'b0000, 256 * g);
        frame(4'b0001, 256 * 9);
        check("retrigger_addr", last_addr0, 0);
        check("retrigger_active", active_out, 4'b0001);
        for (int g = 10; g <= 15; g++) frame(4'b0001, 256 * g);
        for (int g = 14; g >= 0; g--) frame(4'b0000, 256 * g);
        check("release_idle_active", active_out, 4'b0000);

        // One-shot: voice dies after the address-7 read.
        loop_en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            frame(4'b0001, 256 * k);
            check("oneshot_addr", last_addr0, k - 1);
        end
        check("oneshot_end_active", active_out, 4'b0000);
        frame(4'b0001, 0);
        check("oneshot_stays_idle", active_out, 4'b0000);

        // Looping: ninth read wraps to address 0 and the voice stays active.
        loop_en = 1'b1;
        frame(4'b0000, 0);
        for (int k = 1; k <= 8; k++) frame(4'b0001, 256 * k);
        frame(4'b0001, 256 * 9);
        check("loop_wrap_addr", last_addr0, 0);
        check("loop_active", active_out, 4'b0001);

        // After reset a held gate counts as a rising edge; ramp all four voices.
        gate_in = 4'b1111;
        pulse_reset();
        for (int k = 1; k <= 15; k++) frame(4'b1111, 1024 * k);
        check("all_active", active_out, 4'b1111);
        set_data(32767, 32767, 32767, 32767);
        frame(4'b1111, 32767);
        set_data(-32768, -32768, -32768, -32768);
        frame(4'b1111, -32768);
        set_data(1000, -1000, 3000, -4000);
        frame(4'b1111, -939);

        // Ticks while busy, including during the sample_valid cycle, are ignored.
        set_data(-32768, -32768, -32768, -32768);
        rd0 = rd_count;
        v0  = valid_count;
        issue_tick(4'b1111, -32768);
        repeat (2) @(negedge clk_in);
        sample_tick = 1'b1;
        @(posedge clk_in);
        #1 sample_tick = 1'b0;
        n = 0;
        while (!sample_valid && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        if (!sample_valid) check("valid_timeout", 1, 0);
        sample_tick = 1'b1;
        @(posedge clk_in);
        #1 sample_tick = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk_in);
        check("busy_tick_reads", rd_count - rd0, NV);
        check("busy_tick_valids", valid_count - v0, 1);

        // Reset mid-frame clears outputs immediately.
        set_data(4096, 4096, 4096, 4096);
        @(negedge clk_in);
        sample_tick = 1'b1;
        @(posedge clk_in);
        #1 sample_tick = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("midrst_sample_out", sample_out, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_rd", mem_rd_out, 0);
        check("midrst_voice", mem_voice_out, 0);
        check("midrst_addr", mem_addr_out, 0);
        check("midrst_active", active_out, 0);
        check("midrst_busy", busy_out, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        frame(4'b1111, 1024);
        check("post_rst_active", active_out, 4'b1111);

        repeat (10) @(negedge clk_in);
        check("pending_expectations", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
